// File: rtl/trena_sequenciador_if.sv
`default_nettype none
// trena_sequenciador_if: handshake bundle between the sonar sequencer (master) and its datapath (slave).
interface trena_sequenciador_if;
  logic       ligar;
  logic       sensor_pronto;
  logic       serial_pronto;
  logic       medicao;
  logic       transmissao;
  logic [2:0] sel;
  logic       avanca;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    input  ligar, sensor_pronto, serial_pronto,
    output medicao, transmissao, sel, avanca, timeout, db_estado
  );

  modport slave (
    output ligar, sensor_pronto, serial_pronto,
    input  medicao, transmissao, sel, avanca, timeout, db_estado
  );
endinterface
`default_nettype wire

// File: rtl/trena_sequenciador.sv
`default_nettype none
// trena_sequenciador: measure -> transmit ASCII frame -> advance servo control unit (rev 1.0).
// Define TRENA_DELIMITADOR_EN for the 8-character frame with ',' separator and '#' terminator.
module trena_sequenciador #(
  parameter int INTERVALO = 25_000_000,
  parameter int TIMEOUT   = 2_000_000
) (
  input  logic                 clock,
  input  logic                 reset,
  trena_sequenciador_if.master bus
);

  localparam int MAXCNT = (INTERVALO > TIMEOUT) ? INTERVALO : TIMEOUT;
  localparam int CW     = (MAXCNT > 1) ? $clog2(MAXCNT) : 1;
  localparam logic [CW-1:0] CNT_TIMEOUT   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_INTERVALO = CW'(INTERVALO - 1);

`ifdef TRENA_DELIMITADOR_EN
  localparam logic [2:0] ULTIMO = 3'd7;
`else
  localparam logic [2:0] ULTIMO = 3'd5;
`endif

  typedef enum logic [3:0] {
    INICIAL          = 4'd0,
    MEDE             = 4'd1,
    AGUARDA_MEDIDA   = 4'd2,
    TRANSMITE        = 4'd3,
    AGUARDA_TX       = 4'd4,
    PROXIMO_CHAR     = 4'd5,
    FIM_FRAME        = 4'd6,
    ESPERA_INTERVALO = 4'd7
  } estado_t;

  estado_t       estado;
  estado_t       proximo;
  logic          estourou;
  logic [CW-1:0] contador;
  logic [2:0]    indice;
  logic [2:0]    sel_reg;
  logic          timeout_reg;

  // Character index -> mux select, in frame transmission order.
  function automatic logic [2:0] mapa_sel(input logic [2:0] idx);
`ifdef TRENA_DELIMITADOR_EN
    case (idx)
      3'd0:    mapa_sel = 3'd5;
      3'd1:    mapa_sel = 3'd4;
      3'd2:    mapa_sel = 3'd3;
      3'd3:    mapa_sel = 3'd6;
      3'd4:    mapa_sel = 3'd2;
      3'd5:    mapa_sel = 3'd1;
      3'd6:    mapa_sel = 3'd0;
      default: mapa_sel = 3'd7;
    endcase
`else
    mapa_sel = 3'd5 - idx;
`endif
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo  = estado;
    estourou = 1'b0;
    case (estado)
      INICIAL:
        if (bus.ligar) proximo = MEDE;
      MEDE:
        proximo = AGUARDA_MEDIDA;
      AGUARDA_MEDIDA:
        if (bus.sensor_pronto) begin
          proximo = TRANSMITE;
        end else if (contador == CNT_TIMEOUT) begin
          proximo  = TRANSMITE;
          estourou = 1'b1;
        end
      TRANSMITE:
        proximo = AGUARDA_TX;
      AGUARDA_TX:
        if (bus.serial_pronto) proximo = (indice == ULTIMO) ? FIM_FRAME : PROXIMO_CHAR;
      PROXIMO_CHAR:
        proximo = TRANSMITE;
      FIM_FRAME:
        proximo = ESPERA_INTERVALO;
      ESPERA_INTERVALO:
        if (contador == CNT_INTERVALO) proximo = bus.ligar ? MEDE : INICIAL;
      default:
        proximo = INICIAL;
    endcase
  end

  // Index and sel are loaded on entry to MEDE / PROXIMO_CHAR so sel is valid during those states.
  always_ff @(posedge clock) begin
    if (reset) begin
      contador    <= '0;
      indice      <= 3'd0;
      sel_reg     <= 3'd5;
      timeout_reg <= 1'b0;
    end else begin
      if (estado == AGUARDA_MEDIDA || estado == ESPERA_INTERVALO) begin
        contador <= contador + CW'(1);
      end else begin
        contador <= '0;
      end

      if (proximo == MEDE) begin
        indice      <= 3'd0;
        sel_reg     <= mapa_sel(3'd0);
        timeout_reg <= 1'b0;
      end else if (proximo == PROXIMO_CHAR) begin
        indice  <= indice + 3'd1;
        sel_reg <= mapa_sel(indice + 3'd1);
      end

      if (estourou) timeout_reg <= 1'b1;
    end
  end

  assign bus.medicao     = (estado == MEDE);
  assign bus.transmissao = (estado == TRANSMITE);
  assign bus.avanca      = (estado == FIM_FRAME);
  assign bus.sel         = sel_reg;
  assign bus.timeout     = timeout_reg;
  assign bus.db_estado   = estado;

endmodule
`default_nettype wire

// File: tb/tb_trena_sequenciador.sv
`default_nettype none
// tb_trena_sequenciador: directed vector table plus multi-cycle sequences for trena_sequenciador.
module tb_trena_sequenciador;

  localparam int INTERVALO    = 30;
  localparam int TIMEOUT      = 100;
  localparam int INTERVALO_TO = 5;
  localparam int TIMEOUT_TO   = 10;
  localparam int SENS_DLY     = 50;
  localparam int SER_DLY      = 20;
`ifdef TRENA_DELIMITADOR_EN
  localparam int NCHAR = 8;
`else
  localparam int NCHAR = 6;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  trena_sequenciador_if bus ();
  trena_sequenciador_if bus_to ();

  trena_sequenciador #(.INTERVALO(INTERVALO), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  trena_sequenciador #(.INTERVALO(INTERVALO_TO), .TIMEOUT(TIMEOUT_TO)) dut_to (
    .clock(clock), .reset(reset), .bus(bus_to)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       ligar;
    logic       sensor;
    logic       serial;
    logic       med;
    logic       tx;
    logic       av;
    logic       to;
    logic [2:0] sel;
    logic [3:0] st;
  } vec_t;

  vec_t tab [13];

  int checks = 0;
  int fails  = 0;
  int cyc = 0;
  int tx_cnt = 0, av_cnt = 0, med_cnt = 0, to_hi = 0, sel67 = 0;
  int last_av = 0, last_med = 0;
  int since_med = 1000, since_tx = 1000, since_tx2 = 1000;
  bit auto_resp = 1'b0;
  logic [2:0] tx_sel [16];

  function automatic int exp_sel(input int i);
`ifdef TRENA_DELIMITADOR_EN
    case (i)
      0: return 5; 1: return 4; 2: return 3; 3: return 6;
      4: return 2; 5: return 1; 6: return 0; default: return 7;
    endcase
`else
    return 5 - i;
`endif
  endfunction

  function automatic vec_t mk(input int l, input int s, input int r, input int m,
                              input int t, input int a, input int o, input int sl, input int st);
    vec_t v;
    v.ligar = l[0]; v.sensor = s[0]; v.serial = r[0];
    v.med = m[0]; v.tx = t[0]; v.av = a[0]; v.to = o[0];
    v.sel = sl[2:0]; v.st = st[3:0];
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: sample at the falling edge, then drive the responder inputs.
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (bus.transmissao) begin
      if (tx_cnt < 16) tx_sel[tx_cnt] = bus.sel;
      tx_cnt++;
      if (bus.timeout) to_hi++;
      since_tx = 0;
    end else begin
      since_tx++;
    end
    if (bus.sel == 3'd6 || bus.sel == 3'd7) sel67++;
    if (bus.avanca) begin av_cnt++; last_av = cyc; end
    if (bus.medicao) begin med_cnt++; last_med = cyc; since_med = 0; end
    else since_med++;
    if (bus_to.transmissao) since_tx2 = 0; else since_tx2++;
    bus.sensor_pronto    = 1'b0;
    bus.serial_pronto    = 1'b0;
    bus_to.serial_pronto = (since_tx2 == 3);
    if (auto_resp) begin
      bus.sensor_pronto = (since_med == SENS_DLY);
      bus.serial_pronto = (since_tx == SER_DLY);
    end
  endtask

  task automatic clear_mon();
    tx_cnt = 0; av_cnt = 0; med_cnt = 0; to_hi = 0; sel67 = 0;
  endtask

  initial begin
    int idle_bad, got, m_cyc, t_cyc, tx2, to2_lo;
    bus.ligar = 1'b0; bus.sensor_pronto = 1'b0; bus.serial_pronto = 1'b0;
    bus_to.ligar = 1'b0; bus_to.sensor_pronto = 1'b0; bus_to.serial_pronto = 1'b0;

    tab[0]  = mk(1,0,0, 0,0,0,0, 5,0);
    tab[1]  = mk(1,0,0, 1,0,0,0, 5,1);
    tab[2]  = mk(1,0,1, 0,0,0,0, 5,2);
    tab[3]  = mk(1,1,0, 0,0,0,0, 5,2);
    tab[4]  = mk(1,0,0, 0,1,0,0, 5,3);
    tab[5]  = mk(1,1,0, 0,0,0,0, 5,4);
    tab[6]  = mk(1,0,1, 0,0,0,0, 5,4);
    tab[7]  = mk(1,0,0, 0,0,0,0, 4,5);
    tab[8]  = mk(1,0,0, 0,1,0,0, 4,3);
    tab[9]  = mk(1,0,1, 0,0,0,0, 4,4);
    tab[10] = mk(1,0,0, 0,0,0,0, 3,5);
    tab[11] = mk(1,0,0, 0,1,0,0, 3,3);
    tab[12] = mk(0,0,0, 0,0,0,0, 3,4);

    repeat (3) tick();
    reset = 1'b0;

    check("reset_db_estado", int'(bus.db_estado), 0);
    check("reset_sel", int'(bus.sel), 5);
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.medicao || bus.transmissao || bus.avanca || bus.timeout ||
          bus.db_estado != 4'd0 || bus.sel != 3'd5) idle_bad++;
    end
    check("idle_quiet", idle_bad, 0);

    for (int i = 0; i < 13; i++) begin
      tick();
      check($sformatf("vec%0d_medicao", i),     int'(bus.medicao),     int'(tab[i].med));
      check($sformatf("vec%0d_transmissao", i), int'(bus.transmissao), int'(tab[i].tx));
      check($sformatf("vec%0d_avanca", i),      int'(bus.avanca),      int'(tab[i].av));
      check($sformatf("vec%0d_timeout", i),     int'(bus.timeout),     int'(tab[i].to));
      check($sformatf("vec%0d_sel", i),         int'(bus.sel),         int'(tab[i].sel));
      check($sformatf("vec%0d_db_estado", i),   int'(bus.db_estado),   int'(tab[i].st));
      bus.ligar         = tab[i].ligar;
      bus.sensor_pronto = tab[i].sensor;
      bus.serial_pronto = tab[i].serial;
    end

    // Reset while waiting on the serial transmitter, then a stray serial_pronto.
    reset = 1'b1;
    tick();
    check("rst_aguarda_tx_estado", int'(bus.db_estado), 0);
    check("rst_aguarda_tx_sel", int'(bus.sel), 5);
    reset = 1'b0;
    bus.serial_pronto = 1'b1;
    clear_mon();
    for (int i = 0; i < 10; i++) tick();
    check("stray_serial_tx", tx_cnt, 0);
    check("stray_serial_estado", int'(bus.db_estado), 0);

    // Full frame with sensor answering after SENS_DLY and each character after SER_DLY.
    clear_mon();
    bus.ligar = 1'b1;
    auto_resp = 1'b1;
    got = 0;
    for (int i = 0; i < 3000 && got == 0; i++) begin
      tick();
      if (med_cnt == 2) got = 1;
    end
    check("frame_second_medicao_seen", got, 1);
    check("frame_tx_count", tx_cnt, NCHAR);
    for (int i = 0; i < NCHAR; i++) check($sformatf("frame_sel%0d", i), int'(tx_sel[i]), exp_sel(i));
    check("frame_avanca_count", av_cnt, 1);
    check("frame_timeout_hi", to_hi, 0);
    check("frame_interval", last_med - last_av, INTERVALO + 1);
`ifndef TRENA_DELIMITADOR_EN
    check("frame_sel_never_6_7", sel67, 0);
`endif

    // ligar drops during the 3rd character of the following frame.
    clear_mon();
    got = 0;
    for (int i = 0; i < 3000 && got == 0; i++) begin
      tick();
      if (tx_cnt == 3) got = 1;
    end
    check("drop_third_char_seen", got, 1);
    bus.ligar = 1'b0;
    got = 0;
    for (int i = 0; i < 3000 && got == 0; i++) begin
      tick();
      if (av_cnt == 1) got = 1;
    end
    check("drop_avanca_seen", got, 1);
    check("drop_tx_count", tx_cnt, NCHAR);
    for (int i = 0; i < INTERVALO + 40; i++) tick();
    check("drop_no_medicao", med_cnt, 0);
    check("drop_estado_inicial", int'(bus.db_estado), 0);
    auto_resp = 1'b0;

    // Timeout instance: no sensor_pronto at all.
    bus_to.ligar = 1'b1;
    got = 0; m_cyc = 0; t_cyc = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      tick();
      if (bus_to.medicao) begin got = 1; m_cyc = cyc; end
    end
    check("to_medicao_seen", got, 1);
    got = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      tick();
      if (bus_to.transmissao) begin got = 1; t_cyc = cyc; end
    end
    check("to_tx_seen", got, 1);
    check("to_tx_latency", t_cyc - m_cyc, TIMEOUT_TO + 1);
    check("to_flag_at_tx", int'(bus_to.timeout), 1);
    tx2 = 1; to2_lo = 0; got = 0;
    for (int i = 0; i < 500 && got == 0; i++) begin
      tick();
      if (bus_to.transmissao) begin
        tx2++;
        if (!bus_to.timeout) to2_lo++;
      end
      if (bus_to.avanca && !bus_to.timeout) to2_lo++;
      if (bus_to.medicao) got = 1;
    end
    check("to_next_medicao_seen", got, 1);
    check("to_tx_count", tx2, NCHAR);
    check("to_flag_whole_frame", to2_lo, 0);
    bus_to.ligar = 1'b0;
    tick();
    check("to_flag_cleared", int'(bus_to.timeout), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
